pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
Consumes the PLL lock indication and generates ordered, glitch-free synchronous resets for the SDRAM controller and the system (CPU, memory, I/O) domain. It runs on the 50 MHz system clock. It debounces lock, releases the SDRAM controller first, and waits for SDRAM initialisation, with timeout and retry. Only then does it release the system reset. Any loss of lock mid-operation returns every consumer to reset.

Parameters:
SYNC_STAGES, 2, synchroniser flops on pll_locked (min 2)
LOCK_STABLE, 1024, consecutive synced-lock cycles required before leaving WAIT_LOCK
SDRAM_HOLD, 16, cycles reset_sdram stays asserted after lock is stable
INIT_TIMEOUT, 65536, max cycles waiting for sdram_init_done before retry
SYS_HOLD, 16, cycles between init_done and reset_system deassert

Ports:
clock  in  1  system clock (50 MHz PLL output)
reset  in  1  synchronous active-high; forces full re-sequence
pll_locked  in  1  PLL lock, asynchronous to clock
sdram_init_done  in  1  level from SDRAM controller; high once init sequence complete
reset_sdram  out  1  active-high reset to SDRAM controller
reset_system  out  1  active-high reset to CPU/memory/I/O
state  out  3  current FSM state encoding (debug/LED)
timeout_flag  out  1  sticky: at least one init timeout since reset
relock_count  out  8  saturating count of lock losses after first RUN

Behaviour:
- Reset, sampled on the rising edge of clock:
  - state=WAIT_LOCK; reset_sdram=1; reset_system=1; timeout_flag=0; relock_count=0.
  - Synchroniser flops and all counters cleared.
- locked_s is pll_locked delayed by SYNC_STAGES flops. All decisions use locked_s only.
- States and encodings: WAIT_LOCK=0, STABLE=1, SDRAM_RST=2, SDRAM_INIT=3, SYS_RST=4, RUN=5.
- WAIT_LOCK: outputs both 1.
  - Counter increments while locked_s=1 and clears when locked_s=0.
  - Go to STABLE when the counter reaches LOCK_STABLE-1 with locked_s still 1.
  - First exit therefore occurs exactly LOCK_STABLE cycles after locked_s rises.
- STABLE: one cycle; clears the counter; go to SDRAM_RST.
- SDRAM_RST: reset_sdram=1; after SDRAM_HOLD cycles go to SDRAM_INIT.
- SDRAM_INIT:
  - reset_sdram=0, reset_system=1; counter counts cycles in state.
  - sdram_init_done=1 → SYS_RST, counter cleared.
  - Counter reaches INIT_TIMEOUT-1 without done → set timeout_flag, go to SDRAM_RST (retry, unlimited).
  - Done and timeout on the same cycle: done wins, no flag set.
- SYS_RST: reset_sdram=0, reset_system=1.
  - After SYS_HOLD cycles go to RUN.
  - If sdram_init_done drops during SYS_RST, go to SDRAM_RST.
- RUN: both resets 0; remains until lock loss.
- Lock loss:
  - locked_s=0 in any state other than WAIT_LOCK → next cycle state=WAIT_LOCK, both resets=1, counter cleared.
  - This rule has priority over all other transitions.
  - relock_count increments (saturating at 255) only when the loss occurs in RUN.
- Output registration and glitch rules:
  - reset_sdram and reset_system are registered FSM outputs, glitch-free.
  - They change on the cycle after the state that defines them is entered.
  - reset_system is never 0 while reset_sdram is 1.
- Counter width is $clog2 of the largest parameter, plus 1.
- reset asserted mid-sequence or in RUN behaves identically to power-up reset and clears the sticky flags.

Test Plan:
1. Power-up with defaults; pll_locked rises at cycle 10 and is held; sdram_init_done rises 200 cycles after reset_sdram falls → timing as below, state=5, timeout_flag=0.
   - reset_sdram falls at 10+2+1024+1+16 (±1 for registration).
   - reset_system falls SYS_HOLD+1 cycles after init_done.
2. Lock chatter: pll_locked toggles high 500 cycles / low 3 cycles, repeated 4 times, then stays high → STABLE is entered only 1024 cycles after the final rise; both resets remain 1 throughout.
3. Init timeout with INIT_TIMEOUT=64 and init_done held low → after 64 cycles in state 3, timeout_flag=1 and the FSM returns to state 2.
   - reset_sdram pulses high for 16 cycles, then retries.
   - Raising init_done then reaches RUN with timeout_flag still 1.
4. Lock loss in RUN: drop pll_locked for 1 cycle → within SYNC_STAGES+1 cycles both resets=1 and state=0.
   - relock_count goes 0→1.
   - Repeating 300 times saturates relock_count at 255.
5. Simultaneous events: sdram_init_done rises on the exact timeout cycle → state goes to 4 and timeout_flag stays 0. Separately, pll_locked drops on the same cycle SYS_RST completes → state=0, not 5.
6. reset asserted for 1 cycle while in RUN with timeout_flag=1 and relock_count=3 → all outputs return to reset values, and the full sequence from scenario 1 repeats.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// Purpose: sequences SDRAM-controller and system resets from a debounced PLL lock, with init timeout/retry.
// Latency: lock to reset_sdram release = SYNC_STAGES+LOCK_STABLE+SDRAM_HOLD+1 cycles; init_done to reset_system release = SYS_HOLD+1.
// Backpressure: none; sdram_init_done is a level handshake and any lock loss forces both resets back on.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES  = 2,
  parameter int LOCK_STABLE  = 1024,
  parameter int SDRAM_HOLD   = 16,
  parameter int INIT_TIMEOUT = 65536,
  parameter int SYS_HOLD     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       sdram_init_done,
  output logic       reset_sdram,
  output logic       reset_system,
  output logic [2:0] state,
  output logic       timeout_flag,
  output logic [7:0] relock_count
);

  // One shared cycle counter sized for the longest interval it ever has to measure.
  localparam int MAX_AB = (LOCK_STABLE > SDRAM_HOLD) ? LOCK_STABLE : SDRAM_HOLD;
  localparam int MAX_CD = (INIT_TIMEOUT > SYS_HOLD) ? INIT_TIMEOUT : SYS_HOLD;
  localparam int MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(SDRAM_HOLD - 1);
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_TIMEOUT - 1);
  localparam logic [CW-1:0] SYS_LAST  = CW'(SYS_HOLD - 1);

  typedef enum logic [2:0] {
    S_WAIT_LOCK  = 3'd0,
    S_STABLE     = 3'd1,
    S_SDRAM_RST  = 3'd2,
    S_SDRAM_INIT = 3'd3,
    S_SYS_RST    = 3'd4,
    S_RUN        = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic                   reset_sdram_q;
  logic                   reset_system_q;
  logic                   timeout_flag_q;
  logic [7:0]             relock_q;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Bring the asynchronous lock indication into the clock domain; only the last stage is ever used.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Sequencing FSM: lock loss outranks every other transition; reset outputs are registered from the
  // state held in the previous cycle so they change only on the cycle after a state is entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_WAIT_LOCK;
      cnt_q          <= '0;
      reset_sdram_q  <= 1'b1;
      reset_system_q <= 1'b1;
      timeout_flag_q <= 1'b0;
      relock_q       <= 8'd0;
    end else begin
      // The SDRAM controller runs only in INIT/SYS_RST/RUN, the system only in RUN, so
      // reset_system can never be low while reset_sdram is high.
      reset_sdram_q  <= (state_q == S_WAIT_LOCK) || (state_q == S_STABLE) ||
                        (state_q == S_SDRAM_RST);
      reset_system_q <= (state_q != S_RUN);

      if (!locked_s && (state_q != S_WAIT_LOCK)) begin
        state_q <= S_WAIT_LOCK;
        cnt_q   <= '0;
        if ((state_q == S_RUN) && (relock_q != 8'hFF)) begin
          relock_q <= relock_q + 8'd1;
        end
      end else begin
        case (state_q)
          S_WAIT_LOCK: begin
            if (!locked_s) begin
              cnt_q <= '0;
            end else if (cnt_q == LOCK_LAST) begin
              state_q <= S_STABLE;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_STABLE: begin
            state_q <= S_SDRAM_RST;
            cnt_q   <= '0;
          end
          S_SDRAM_RST: begin
            if (cnt_q == HOLD_LAST) begin
              state_q <= S_SDRAM_INIT;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_SDRAM_INIT: begin
            // A done arriving on the timeout cycle still counts as success.
            if (sdram_init_done) begin
              state_q <= S_SYS_RST;
              cnt_q   <= '0;
            end else if (cnt_q == INIT_LAST) begin
              state_q        <= S_SDRAM_RST;
              cnt_q          <= '0;
              timeout_flag_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_SYS_RST: begin
            // The controller falling out of init sends it back through its own reset.
            if (!sdram_init_done) begin
              state_q <= S_SDRAM_RST;
              cnt_q   <= '0;
            end else if (cnt_q == SYS_LAST) begin
              state_q <= S_RUN;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_RUN: begin
            cnt_q <= '0;
          end
          default: begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign reset_sdram  = reset_sdram_q;
  assign reset_system = reset_system_q;
  assign state        = state_q;
  assign timeout_flag = timeout_flag_q;
  assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Purpose: randomized scenario bench for pll_reset_sequencer; expected event times come from interval arithmetic.
// Latency: inputs change on the falling edge, outputs are observed on the falling edge after each rising edge.
// Backpressure: none; every wait on the design is bounded by a cycle budget.
module tb_pll_reset_sequencer;
  localparam int SYNC = 2;
  localparam int LS   = 32;
  localparam int SH   = 16;
  localparam int IT   = 64;
  localparam int SYH  = 16;

  logic       clock = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       sdram_init_done;
  logic       reset_sdram;
  logic       reset_system;
  logic [2:0] state;
  logic       timeout_flag;
  logic [7:0] relock_count;

  int cyc    = 0;
  int n_chk  = 0;
  int n_pass = 0;
  int n_viol = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES(SYNC), .LOCK_STABLE(LS), .SDRAM_HOLD(SH), .INIT_TIMEOUT(IT), .SYS_HOLD(SYH)
  ) dut (
    .clock(clock), .reset(reset), .pll_locked(pll_locked), .sdram_init_done(sdram_init_done),
    .reset_sdram(reset_sdram), .reset_system(reset_system), .state(state),
    .timeout_flag(timeout_flag), .relock_count(relock_count)
  );

  always #5 clock = ~clock;

  // Index of the most recent rising edge.
  always @(posedge clock) cyc <= cyc + 1;

  // The system must never run while the SDRAM controller is held in reset.
  always @(negedge clock) begin
    if (reset_system === 1'b0 && reset_sdram === 1'b1) n_viol++;
  end

  function automatic logic [7:0] probe(input int which);
    case (which)
      0:       probe = {7'd0, reset_sdram};
      1:       probe = {7'd0, reset_system};
      default: probe = {5'd0, state};
    endcase
  endfunction

  // Returns the rising-edge index at which the probed output first shows val (checked now, then each cycle), -1 on expiry.
  task automatic wait_sig(input int which, input logic [7:0] val, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if (probe(which) === val) begin
        at = cyc;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; pll_locked = 1'b0; sdram_init_done = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (state !== 3'd0) $display("FAIL rst_state got %0d exp 0", state); else n_pass++;
    n_chk++; if (reset_sdram !== 1'b1) $display("FAIL rst_sdram got %b exp 1", reset_sdram); else n_pass++;
    n_chk++; if (reset_system !== 1'b1) $display("FAIL rst_system got %b exp 1", reset_system); else n_pass++;
    n_chk++; if (timeout_flag !== 1'b0) $display("FAIL rst_tflag got %b exp 0", timeout_flag); else n_pass++;
    n_chk++; if (relock_count !== 8'd0) $display("FAIL rst_relock got %0d exp 0", relock_count); else n_pass++;
    repeat (20) @(negedge clock);
    n_chk++; if (state !== 3'd0 || reset_sdram !== 1'b1) $display("FAIL rst_idle got st=%0d rs=%b exp st=0 rs=1", state, reset_sdram); else n_pass++;
  endtask

  task automatic test_powerup();
    int k, w, lk, f, d, at;
    k = $urandom_range(2, 12);
    repeat (k) @(negedge clock);
    pll_locked = 1'b1; lk = cyc + 1;
    f = lk + SYNC + LS + SH + 1;
    wait_sig(0, 8'd0, 300, at);
    n_chk++; if (at !== f) $display("FAIL pwr_sdram_fall got %0d exp %0d", at, f); else n_pass++;
    n_chk++; if (state !== 3'd3 || reset_system !== 1'b1) $display("FAIL pwr_init_state got st=%0d rsys=%b exp st=3 rsys=1", state, reset_system); else n_pass++;
    w = $urandom_range(0, 40);
    repeat (w) @(negedge clock);
    sdram_init_done = 1'b1; d = cyc + 1;
    wait_sig(1, 8'd0, 300, at);
    n_chk++; if (at !== d + SYH + 1) $display("FAIL pwr_sys_fall got %0d exp %0d", at, d + SYH + 1); else n_pass++;
    n_chk++; if (state !== 3'd5) $display("FAIL pwr_run_state got %0d exp 5", state); else n_pass++;
    n_chk++; if (timeout_flag !== 1'b0 || reset_sdram !== 1'b0) $display("FAIL pwr_flags got tf=%b rs=%b exp tf=0 rs=0", timeout_flag, reset_sdram); else n_pass++;
  endtask

  task automatic test_lock_chatter();
    int h, lo, lk, at, bad;
    do_reset();
    bad = 0;
    for (int r = 0; r < 4; r++) begin
      h = $urandom_range(4, LS - 1);
      pll_locked = 1'b1;
      repeat (h) begin
        @(negedge clock);
        if (state !== 3'd0 || reset_sdram !== 1'b1 || reset_system !== 1'b1) bad++;
      end
      lo = $urandom_range(1, 3);
      pll_locked = 1'b0;
      repeat (lo) begin
        @(negedge clock);
        if (state !== 3'd0 || reset_sdram !== 1'b1 || reset_system !== 1'b1) bad++;
      end
    end
    n_chk++; if (bad !== 0) $display("FAIL chat_held got %0d bad cycles exp 0", bad); else n_pass++;
    pll_locked = 1'b1; lk = cyc + 1;
    wait_sig(2, 8'd1, 300, at);
    n_chk++; if (at !== lk + SYNC - 1 + LS) $display("FAIL chat_stable_edge got %0d exp %0d", at, lk + SYNC - 1 + LS); else n_pass++;
    n_chk++; if (reset_sdram !== 1'b1 || reset_system !== 1'b1) $display("FAIL chat_resets got rs=%b rsys=%b exp 1 1", reset_sdram, reset_system); else n_pass++;
  endtask

  // Continues from STABLE with init_done held low.
  task automatic test_init_timeout();
    int s, f, t, r, f2, w, d, at;
    s = cyc;
    wait_sig(0, 8'd0, 200, f);
    n_chk++; if (f !== s + SH + 2) $display("FAIL tmo_sdram_fall got %0d exp %0d", f, s + SH + 2); else n_pass++;
    n_chk++; if (timeout_flag !== 1'b0) $display("FAIL tmo_flag_before got %b exp 0", timeout_flag); else n_pass++;
    t = f - 1 + IT;
    wait_sig(2, 8'd2, 300, at);
    n_chk++; if (at !== t) $display("FAIL tmo_retry_edge got %0d exp %0d", at, t); else n_pass++;
    n_chk++; if (timeout_flag !== 1'b1) $display("FAIL tmo_flag_set got %b exp 1", timeout_flag); else n_pass++;
    wait_sig(0, 8'd1, 20, r);
    n_chk++; if (r !== t + 1) $display("FAIL tmo_sdram_rise got %0d exp %0d", r, t + 1); else n_pass++;
    wait_sig(0, 8'd0, 100, f2);
    n_chk++; if (f2 - r !== SH) $display("FAIL tmo_pulse_len got %0d exp %0d", f2 - r, SH); else n_pass++;
    w = $urandom_range(0, 40);
    repeat (w) @(negedge clock);
    sdram_init_done = 1'b1; d = cyc + 1;
    wait_sig(1, 8'd0, 300, at);
    n_chk++; if (at !== d + SYH + 1) $display("FAIL tmo_sys_fall got %0d exp %0d", at, d + SYH + 1); else n_pass++;
    n_chk++; if (state !== 3'd5 || timeout_flag !== 1'b1) $display("FAIL tmo_run got st=%0d tf=%b exp st=5 tf=1", state, timeout_flag); else n_pass++;
  endtask

  // Continues from RUN with relock_count 0 and init_done held high.
  task automatic test_lock_loss();
    int p, lo, at, exp_rc;
    pll_locked = 1'b0; p = cyc + 1;
    @(negedge clock);
    pll_locked = 1'b1;
    @(negedge clock);
    n_chk++; if (state !== 3'd5) $display("FAIL loss_not_early got %0d exp 5", state); else n_pass++;
    @(negedge clock);
    n_chk++; if (state !== 3'd0 || cyc !== p + SYNC) $display("FAIL loss_state got st=%0d at %0d exp st=0 at %0d", state, cyc, p + SYNC); else n_pass++;
    @(negedge clock);
    n_chk++; if (reset_sdram !== 1'b1 || reset_system !== 1'b1) $display("FAIL loss_resets got rs=%b rsys=%b exp 1 1", reset_sdram, reset_system); else n_pass++;
    n_chk++; if (relock_count !== 8'd1) $display("FAIL loss_relock1 got %0d exp 1", relock_count); else n_pass++;
    for (int n = 2; n <= 300; n++) begin
      wait_sig(2, 8'd5, 400, at);
      if (at < 0) begin
        n_chk++; $display("FAIL loss_reach_run got timeout exp state 5 (iteration %0d)", n);
        break;
      end
      lo = $urandom_range(1, 3);
      pll_locked = 1'b0;
      repeat (lo) @(negedge clock);
      pll_locked = 1'b1;
      wait_sig(2, 8'd0, 20, at);
      if (at < 0) begin
        n_chk++; $display("FAIL loss_reach_wait got timeout exp state 0 (iteration %0d)", n);
        break;
      end
      exp_rc = (n > 255) ? 255 : n;
      if (n <= 5 || n >= 250) begin
        n_chk++; if (relock_count !== exp_rc[7:0]) $display("FAIL loss_relock got %0d exp %0d", relock_count, exp_rc); else n_pass++;
      end
    end
  endtask

  task automatic test_simultaneous();
    int f, t;
    do_reset();
    pll_locked = 1'b1;
    wait_sig(0, 8'd0, 300, f);
    t = f - 1 + IT;
    while (cyc < t - 1) @(negedge clock);
    sdram_init_done = 1'b1;
    @(negedge clock);
    n_chk++; if (state !== 3'd4) $display("FAIL sim_done_wins got %0d exp 4", state); else n_pass++;
    n_chk++; if (timeout_flag !== 1'b0) $display("FAIL sim_no_flag got %b exp 0", timeout_flag); else n_pass++;
    // Synced lock falls exactly on the edge where the SYS_RST hold would expire.
    while (cyc < t + SYH - SYNC - 1) @(negedge clock);
    pll_locked = 1'b0;
    while (cyc < t + SYH) @(negedge clock);
    n_chk++; if (state !== 3'd0) $display("FAIL sim_loss_beats_run got %0d exp 0", state); else n_pass++;
    @(negedge clock);
    n_chk++; if (reset_system !== 1'b1 || relock_count !== 8'd0) $display("FAIL sim_after got rsys=%b rc=%0d exp 1 0", reset_system, relock_count); else n_pass++;
  endtask

  task automatic test_reset_in_run();
    int f, at, w, r, lk, d;
    do_reset();
    pll_locked = 1'b1;
    wait_sig(2, 8'd3, 300, at);
    wait_sig(2, 8'd2, 300, at);
    sdram_init_done = 1'b1;
    wait_sig(2, 8'd5, 300, at);
    for (int i = 0; i < 3; i++) begin
      pll_locked = 1'b0;
      @(negedge clock);
      pll_locked = 1'b1;
      wait_sig(2, 8'd0, 20, at);
      wait_sig(2, 8'd5, 400, at);
    end
    n_chk++; if (state !== 3'd5 || timeout_flag !== 1'b1 || relock_count !== 8'd3) $display("FAIL rr_setup got st=%0d tf=%b rc=%0d exp 5 1 3", state, timeout_flag, relock_count); else n_pass++;
    w = $urandom_range(0, 10);
    repeat (w) @(negedge clock);
    reset = 1'b1; sdram_init_done = 1'b0; r = cyc + 1;
    @(negedge clock);
    reset = 1'b0;
    n_chk++; if (state !== 3'd0 || reset_sdram !== 1'b1 || reset_system !== 1'b1) $display("FAIL rr_outputs got st=%0d rs=%b rsys=%b exp 0 1 1", state, reset_sdram, reset_system); else n_pass++;
    n_chk++; if (timeout_flag !== 1'b0 || relock_count !== 8'd0) $display("FAIL rr_sticky got tf=%b rc=%0d exp 0 0", timeout_flag, relock_count); else n_pass++;
    lk = r + 1;
    wait_sig(0, 8'd0, 300, f);
    n_chk++; if (f !== lk + SYNC + LS + SH + 1) $display("FAIL rr_sdram_fall got %0d exp %0d", f, lk + SYNC + LS + SH + 1); else n_pass++;
    w = $urandom_range(0, 40);
    repeat (w) @(negedge clock);
    sdram_init_done = 1'b1; d = cyc + 1;
    wait_sig(1, 8'd0, 300, at);
    n_chk++; if (at !== d + SYH + 1) $display("FAIL rr_sys_fall got %0d exp %0d", at, d + SYH + 1); else n_pass++;
    n_chk++; if (state !== 3'd5 || timeout_flag !== 1'b0) $display("FAIL rr_run got st=%0d tf=%b exp 5 0", state, timeout_flag); else n_pass++;
  endtask

  task automatic test_ordering();
    n_chk++; if (n_viol !== 0) $display("FAIL ordering got %0d cycles with system out of reset during sdram reset exp 0", n_viol); else n_pass++;
  endtask

  initial begin
    reset = 1'b1; pll_locked = 1'b0; sdram_init_done = 1'b0;
    test_reset();
    test_powerup();
    test_lock_chatter();
    test_init_timeout();
    test_lock_loss();
    test_simultaneous();
    test_reset_in_run();
    test_ordering();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
